edge_preserve_filter: RTL and testbench

- Pixel-processing core between the 3x3 window reader and the filtered-image write port.
- Consumes one 3x3 window per cycle (sw_pixel_1..9, row-major, 5 = centre) and produces one filtered pixel (cl_pixel) per accepted window.
- Averages along the direction of least gradient, so edges are preserved; flat regions get a full 3x3 mean.
- Fully pipelined with no stalls; counts output pixels and pulses frame_done on the last pixel of a frame.

---
 rtl/epf_pkg.sv | 21 ++
 rtl/epf_dir_select.sv | 44 ++++
 rtl/edge_preserve_filter.sv | 167 ++++++++++++++++
 tb/tb_edge_preserve_filter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/epf_pkg.sv
// Shared types and constants for the edge-preserving 3x3 filter.
package epf_pkg;

  localparam int PIX_W_DEF     = 8;
  localparam int FLAT_TH_DEF   = 8;
  localparam int FRAME_PIX_DEF = 15876;
  localparam int CNT_W         = 14;

  // Full 3x3 mean approximated as sum9 * 57 / 512 (57/512 ~= 1/9).
  localparam int MEAN_MUL = 57;
  localparam int MEAN_SHR = 9;

  // Averaging direction; declaration order is also the tie-break priority.
  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_t;

endpackage

// File: rtl/epf_dir_select.sv
// Picks the direction with the smallest gradient and returns its
// directional sum. Ties go to the earlier direction (H > V > D > A).
module epf_dir_select
  import epf_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] g0,
  input  logic [PIX_W-1:0] g1,
  input  logic [PIX_W-1:0] g2,
  input  logic [PIX_W-1:0] g3,
  input  logic [PIX_W+1:0] s0,
  input  logic [PIX_W+1:0] s1,
  input  logic [PIX_W+1:0] s2,
  input  logic [PIX_W+1:0] s3,
  output dir_t             sel_dir,
  output logic [PIX_W+1:0] sel_sum
);

  logic [PIX_W-1:0] best_g;

  // Strict less-than keeps the earlier direction on a tie.
  always_comb begin
    best_g  = g0;
    sel_dir = DIR_H;
    sel_sum = s0;
    if (g1 < best_g) begin
      best_g  = g1;
      sel_dir = DIR_V;
      sel_sum = s1;
    end
    if (g2 < best_g) begin
      best_g  = g2;
      sel_dir = DIR_D;
      sel_sum = s2;
    end
    if (g3 < best_g) begin
      best_g  = g3;
      sel_dir = DIR_A;
      sel_sum = s3;
    end
  end

endmodule

// File: rtl/edge_preserve_filter.sv
// Edge-preserving 3x3 filter: averages along the direction of least
// gradient, or takes the full 3x3 mean on flat windows. Three register
// stages, no backpressure; counts output pixels per frame.
// Handshake: in_valid qualifies the window in the same cycle and is always
// accepted; out_valid qualifies cl_pixel exactly three cycles later.
module edge_preserve_filter
  import epf_pkg::*;
#(
  parameter int PIX_W     = PIX_W_DEF,
  parameter int FLAT_TH   = FLAT_TH_DEF,
  parameter int FRAME_PIX = FRAME_PIX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] sw_pixel_1,
  input  logic [PIX_W-1:0] sw_pixel_2,
  input  logic [PIX_W-1:0] sw_pixel_3,
  input  logic [PIX_W-1:0] sw_pixel_4,
  input  logic [PIX_W-1:0] sw_pixel_5,
  input  logic [PIX_W-1:0] sw_pixel_6,
  input  logic [PIX_W-1:0] sw_pixel_7,
  input  logic [PIX_W-1:0] sw_pixel_8,
  input  logic [PIX_W-1:0] sw_pixel_9,
  output logic             out_valid,
  output logic [PIX_W-1:0] cl_pixel,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_cnt,
  output dir_t             dbg_dir
);

  localparam int SUM9_W = PIX_W + 4;
  localparam int PROD_W = SUM9_W + 7;
  localparam logic [PIX_W-1:0] FLAT_V     = PIX_W'(FLAT_TH);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIX - 1);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [PIX_W+1:0] dir_sum(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] c,
                                               input logic [PIX_W-1:0] b);
    return {2'b00, a} + {1'b0, c, 1'b0} + {2'b00, b};
  endfunction

  // Stage 1 registers
  logic             s1_valid;
  logic [PIX_W-1:0] p [1:9];

  // Stage 2 registers
  logic              s2_valid;
  logic [PIX_W-1:0]  s2_g0, s2_g1, s2_g2, s2_g3;
  logic [PIX_W+1:0]  s2_s0, s2_s1, s2_s2, s2_s3;
  logic [SUM9_W-1:0] s2_sum9;

  // Stage 3 combinational selection
  dir_t              sel_dir;
  logic [PIX_W+1:0]  sel_sum;
  logic [PIX_W-1:0]  gmax;
  logic [PROD_W-1:0] mean_prod;
  logic [PIX_W-1:0]  mean_pix;
  logic [PIX_W-1:0]  dir_pix;
  logic [PIX_W-1:0]  next_pix;

  // S1: capture the window and its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      for (int i = 1; i <= 9; i++) p[i] <= '0;
    end else begin
      s1_valid <= in_valid;
      p[1] <= sw_pixel_1;
      p[2] <= sw_pixel_2;
      p[3] <= sw_pixel_3;
      p[4] <= sw_pixel_4;
      p[5] <= sw_pixel_5;
      p[6] <= sw_pixel_6;
      p[7] <= sw_pixel_7;
      p[8] <= sw_pixel_8;
      p[9] <= sw_pixel_9;
    end
  end

  // S2: directional gradients, centre-weighted directional sums, 3x3 sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_g0    <= '0;
      s2_g1    <= '0;
      s2_g2    <= '0;
      s2_g3    <= '0;
      s2_s0    <= '0;
      s2_s1    <= '0;
      s2_s2    <= '0;
      s2_s3    <= '0;
      s2_sum9  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_g0    <= abs_diff(p[4], p[6]);
      s2_g1    <= abs_diff(p[2], p[8]);
      s2_g2    <= abs_diff(p[1], p[9]);
      s2_g3    <= abs_diff(p[3], p[7]);
      s2_s0    <= dir_sum(p[4], p[5], p[6]);
      s2_s1    <= dir_sum(p[2], p[5], p[8]);
      s2_s2    <= dir_sum(p[1], p[5], p[9]);
      s2_s3    <= dir_sum(p[3], p[5], p[7]);
      s2_sum9  <= SUM9_W'(p[1]) + SUM9_W'(p[2]) + SUM9_W'(p[3])
                + SUM9_W'(p[4]) + SUM9_W'(p[5]) + SUM9_W'(p[6])
                + SUM9_W'(p[7]) + SUM9_W'(p[8]) + SUM9_W'(p[9]);
    end
  end

  epf_dir_select #(.PIX_W(PIX_W)) u_dir_select (
    .g0      (s2_g0),
    .g1      (s2_g1),
    .g2      (s2_g2),
    .g3      (s2_g3),
    .s0      (s2_s0),
    .s1      (s2_s1),
    .s2      (s2_s2),
    .s3      (s2_s3),
    .sel_dir (sel_dir),
    .sel_sum (sel_sum)
  );

  // S3 combinational: flat windows take the full mean, others the rounded
  // quarter of the least-gradient directional sum.
  always_comb begin
    gmax = s2_g0;
    if (s2_g1 > gmax) gmax = s2_g1;
    if (s2_g2 > gmax) gmax = s2_g2;
    if (s2_g3 > gmax) gmax = s2_g3;
    mean_prod = PROD_W'(s2_sum9) * PROD_W'(MEAN_MUL);
    mean_pix  = PIX_W'(mean_prod >> MEAN_SHR);
    dir_pix   = PIX_W'((sel_sum + (PIX_W + 2)'(2)) >> 2);
    next_pix  = (gmax < FLAT_V) ? mean_pix : dir_pix;
  end

  // S3: output register; cl_pixel and dbg_dir hold across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      cl_pixel  <= '0;
      dbg_dir   <= DIR_H;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        cl_pixel <= next_pix;
        dbg_dir  <= sel_dir;
      end
    end
  end

  // Frame counter: pix_cnt is the index of the pixel currently on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (out_valid) begin
      pix_cnt <= (pix_cnt == FRAME_LAST) ? '0 : pix_cnt + 1'b1;
    end
  end

  assign frame_done = out_valid && (pix_cnt == FRAME_LAST);

endmodule

// File: tb/tb_edge_preserve_filter.sv
// Bench for edge_preserve_filter: directed windows with literal results,
// mid-flight reset, and a full randomly-bubbled frame checked every cycle
// against a behavioural model.
module tb_edge_preserve_filter;
  import epf_pkg::*;

  localparam int FRAME_PIX = 15876;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] sw [1:9];
  logic       out_valid;
  logic [7:0] cl_pixel;
  logic       frame_done;
  logic [13:0] pix_cnt;
  dir_t       dbg_dir;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int out_cnt = 0;

  // Expected-output pipe: {valid, pixel}, three entries deep.
  logic [8:0] exp_q [$];
  logic [7:0] exp_cl;
  int         exp_cnt;

  edge_preserve_filter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sw_pixel_1 (sw[1]),
    .sw_pixel_2 (sw[2]),
    .sw_pixel_3 (sw[3]),
    .sw_pixel_4 (sw[4]),
    .sw_pixel_5 (sw[5]),
    .sw_pixel_6 (sw[6]),
    .sw_pixel_7 (sw[7]),
    .sw_pixel_8 (sw[8]),
    .sw_pixel_9 (sw[9]),
    .out_valid  (out_valid),
    .cl_pixel   (cl_pixel),
    .frame_done (frame_done),
    .pix_cnt    (pix_cnt),
    .dbg_dir    (dbg_dir)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: gradients over the four opposite pairs around the centre; flat
  // windows give floor(sum9*57/512), otherwise the first direction with the
  // minimum gradient gives round-half-up of its weighted sum / 4.
  function automatic int model_dir(input logic [7:0] w [1:9], output int pix);
    int pa [4] = '{4, 2, 1, 3};
    int pb [4] = '{6, 8, 9, 7};
    int g [4];
    int s [4];
    int gmax, best, total;
    total = 0;
    for (int i = 1; i <= 9; i++) total += int'(w[i]);
    gmax = 0;
    for (int k = 0; k < 4; k++) begin
      int a, b;
      a = int'(w[pa[k]]);
      b = int'(w[pb[k]]);
      g[k] = (a > b) ? a - b : b - a;
      s[k] = a + 2 * int'(w[5]) + b;
      if (g[k] > gmax) gmax = g[k];
    end
    best = 0;
    for (int k = 1; k < 4; k++) if (g[k] < g[best]) best = k;
    if (gmax < 8) begin
      pix = (total * 57) / 512;
      return -1;
    end
    pix = (s[best] + 2) / 4;
    return best;
  endfunction

  function automatic int model(input logic [7:0] w [1:9]);
    int pix, d;
    d = model_dir(w, pix);
    return pix;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] w [1:9];
    if (rst) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_cl_pixel", int'(cl_pixel), 0);
      chk("rst_pix_cnt", int'(pix_cnt), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      exp_q = '{9'd0, 9'd0, 9'd0};
      exp_cl = 8'd0;
      exp_cnt = 0;
    end else begin
      e = exp_q.pop_front();
      chk("out_valid", int'(out_valid), int'(e[8]));
      if (e[8]) exp_cl = e[7:0];
      chk("cl_pixel", int'(cl_pixel), int'(exp_cl));
      chk("pix_cnt", int'(pix_cnt), exp_cnt);
      chk("frame_done", int'(frame_done), int'(e[8] && exp_cnt == FRAME_PIX - 1));
      if (frame_done) done_cnt++;
      if (out_valid) out_cnt++;
      if (e[8]) exp_cnt = (exp_cnt == FRAME_PIX - 1) ? 0 : exp_cnt + 1;
      for (int i = 1; i <= 9; i++) w[i] = sw[i];
      exp_q.push_back({in_valid, 8'(model(w))});
    end
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [7:0] w [1:9]);
    @(posedge clk);
    #2;
    in_valid = v;
    for (int i = 1; i <= 9; i++) sw[i] = w[i];
  endtask

  task automatic bubble();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // One window, then wait for it to emerge and compare to a hand value.
  task automatic directed(input string name, input logic [7:0] w [1:9],
                          input int exp_pix, input int exp_dir);
    int mpix, mdir;
    mdir = model_dir(w, mpix);
    chk({"model_", name}, mpix, exp_pix);
    if (exp_dir >= 0) chk({"model_dir_", name}, mdir, exp_dir);
    drive(1'b1, w);
    bubble();
    bubble();
    bubble();
    chk({"valid_", name}, int'(out_valid), 1);
    chk({"pix_", name}, int'(cl_pixel), exp_pix);
    if (exp_dir >= 0) chk({"dir_", name}, int'(dbg_dir), exp_dir);
  endtask

  initial begin
    logic [7:0] w [1:9];
    int sent, done0, out0, base;

    rst = 1'b1;
    in_valid = 1'b0;
    for (int i = 1; i <= 9; i++) sw[i] = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    directed("flat100", w, 100, -1);
    w = '{10, 10, 200, 10, 10, 200, 10, 10, 200};
    directed("vert_edge", w, 10, int'(DIR_V));
    w = '{0, 90, 200, 50, 70, 50, 200, 90, 0};
    w[1] = 8'd0; w[9] = 8'd200; w[3] = 8'd0; w[7] = 8'd200;
    directed("tie_h", w, 60, int'(DIR_H));
    // Equal pairs give zero gradients everywhere, so this takes the mean.
    w = '{0, 90, 0, 50, 70, 50, 0, 90, 0};
    directed("tie_flat", w, 38, -1);
    w = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    directed("all255", w, 255, -1);
    // Checkerboard: every opposite pair matches, so the mean path applies.
    w = '{255, 0, 255, 0, 255, 0, 255, 0, 255};
    directed("checker", w, 141, -1);
    w = '{60, 0, 0, 0, 80, 200, 200, 200, 60};
    directed("diag", w, 70, int'(DIR_D));
    w = '{0, 200, 40, 0, 40, 200, 40, 0, 200};
    directed("anti", w, 40, int'(DIR_A));
    // Threshold boundary: gmax == 8 is directional, gmax == 7 is flat.
    w = '{100, 100, 100, 100, 100, 108, 108, 108, 108};
    directed("gmax8", w, 102, int'(DIR_H));
    w = '{100, 100, 100, 100, 100, 107, 107, 107, 107};
    directed("gmax7", w, 103, -1);

    // Two windows in flight are discarded by a reset.
    w = '{30, 30, 30, 30, 30, 30, 30, 30, 30};
    drive(1'b1, w);
    drive(1'b1, w);
    pulse_reset();
    chk("post_rst_cnt", int'(pix_cnt), 0);
    chk("post_rst_valid", int'(out_valid), 0);
    repeat (4) bubble();
    chk("flushed_valid", int'(out_valid), 0);
    w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    directed("after_rst", w, 100, -1);
    chk("after_rst_cnt", int'(pix_cnt), 0);

    // Full frame with random bubbles, starting from pixel 0.
    pulse_reset();
    done0 = done_cnt;
    out0 = out_cnt;
    sent = 0;
    while (sent < FRAME_PIX) begin
      if ($urandom_range(0, 3) == 0) begin
        bubble();
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          base = $urandom_range(0, 247);
          for (int i = 1; i <= 9; i++) w[i] = 8'(base + $urandom_range(0, 7));
        end else begin
          for (int i = 1; i <= 9; i++) w[i] = 8'($urandom_range(0, 255));
        end
        drive(1'b1, w);
        sent++;
      end
    end
    repeat (5) bubble();
    chk("frame_done_pulses", done_cnt - done0, 1);
    chk("frame_out_count", out_cnt - out0, FRAME_PIX);
    chk("frame_cnt_wrap", int'(pix_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
